aes_sbox_seq: RTL and testbench



---
 rtl/aes_sbox_seq_if.sv | 27 ++
 rtl/aes_sbox_seq.sv | 170 +++++++++++++++++
 tb/tb_aes_sbox_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_sbox_seq_if.sv
// -----------------------------------------------------------------------------
// aes_sbox_seq_if
// Handshake bundle for the sequential forward S-box engine.
//   in_valid / in_ready / in_data    : 128-bit state word into the engine
//   out_valid / out_ready / out_data : substituted state word out of the engine
// Modports:
//   master : the side that supplies words and consumes results (a datapath, a bench)
//   slave  : the engine itself
// -----------------------------------------------------------------------------
interface aes_sbox_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_sbox_seq.sv
// -----------------------------------------------------------------------------
// aes_sbox_seq
// Sequential forward AES SubBytes engine. One 128-bit state word is accepted,
// its 16 bytes are pushed through the FIPS-197 forward S-box LANES bytes per
// clock in ascending byte order (byte k = data[127-8k -: 8]), and the result is
// offered until the consumer takes it.
//
// Ports:
//   clk    : clock, everything on the rising edge
//   rst    : synchronous active-high reset
//   clear  : synchronous abort, drops any word in flight (rst wins over clear)
//   bus    : aes_sbox_seq_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/out_data)
//   busy   : high while lookups are in progress
//
// Parameter LANES (1, 2, 4, 8, 16): S-box lookups per cycle; NCHUNK = 16/LANES.
//
// Build option AES_SBOX_PIPE_EN: when defined, lookup results are registered
// before write-back, so each chunk costs two cycles (BUSY = lookup,
// PIPE = write-back) and the latency becomes 2*NCHUNK.
// -----------------------------------------------------------------------------
module aes_sbox_seq #(
    parameter int LANES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    aes_sbox_seq_if.slave bus,
    output logic          busy
);

    localparam int NCHUNK = 16 / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    // FIPS-197 forward S-box, entry i at [2047-8i -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
`ifdef AES_SBOX_PIPE_EN
        , S_PIPE = 2'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  data_q, data_d;

    logic [3:0]    lane_idx [LANES];
    logic [7:0]    lut_in   [LANES];
    logic [7:0]    lut_out  [LANES];

`ifdef AES_SBOX_PIPE_EN
    logic [7:0]    pipe_q   [LANES];
    logic [7:0]    pipe_d   [LANES];
`endif

    // Lane gi of chunk cnt works on byte k = cnt*LANES + gi.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_idx[gi] = 4'(int'(cnt_q) * LANES + gi);
            assign lut_in[gi]   = data_q[127 - 8*lane_idx[gi] -: 8];
            assign lut_out[gi]  = SBOX_TABLE[2047 - 8*lut_in[gi] -: 8];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef AES_SBOX_PIPE_EN
        pipe_d  = pipe_q;
`endif
        if (clear) begin
            // Abort beats both handshakes; the data register keeps its contents.
            state_d = S_IDLE;
            cnt_d   = '0;
`ifdef AES_SBOX_PIPE_EN
            for (int i = 0; i < LANES; i++) pipe_d[i] = 8'h00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        data_d  = bus.in_data;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end
                end
`ifdef AES_SBOX_PIPE_EN
                S_BUSY: begin
                    pipe_d  = lut_out;
                    state_d = S_PIPE;
                end
                S_PIPE: begin
                    for (int i = 0; i < LANES; i++)
                        data_d[127 - 8*int'(lane_idx[i]) -: 8] = pipe_q[i];
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_BUSY;
                    end
                end
`else
                S_BUSY: begin
                    for (int i = 0; i < LANES; i++)
                        data_d[127 - 8*int'(lane_idx[i]) -: 8] = lut_out[i];
                    // Counter saturates on the last chunk instead of wrapping.
                    if (cnt_q == LAST_CNT) state_d = S_DONE;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef AES_SBOX_PIPE_EN
            for (int i = 0; i < LANES; i++) pipe_q[i] <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef AES_SBOX_PIPE_EN
            pipe_q  <= pipe_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    // The data register doubles as the output register; it holds its value
    // after the handshake until the next word is loaded.
    assign bus.out_data  = data_q;
`ifdef AES_SBOX_PIPE_EN
    assign busy = (state_q == S_BUSY) || (state_q == S_PIPE);
`else
    assign busy = (state_q == S_BUSY);
`endif

endmodule

// File: tb/tb_aes_sbox_seq.sv
module tb_aes_sbox_seq;

    localparam int LANES  = 4;
    localparam int NCHUNK = 16 / LANES;
`ifdef AES_SBOX_PIPE_EN
    localparam int LAT = 2 * NCHUNK;
`else
    localparam int LAT = NCHUNK;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic busy;

    aes_sbox_seq_if bus ();

    aes_sbox_seq #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [127:0] sb_q [$];
    logic [7:0] sbox_m [256];
    logic [7:0] inv_m  [256];

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Forward S-box derived from GF(2^8) inversion plus the affine transform.
    task automatic build_model();
        logic [7:0] b;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            sbox_m[x] = s;
        end
        for (int x = 0; x < 256; x++) inv_m[sbox_m[x]] = 8'(x);
    endtask

    function automatic logic [127:0] sub_word(input logic [127:0] d);
        logic [127:0] r = '0;
        for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = sbox_m[d[127 - 8*k -: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer a word, wait (bounded) for acceptance, push the expected result.
    task automatic send(input logic [127:0] d, output int waits);
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && waits < 100) begin
            @(posedge clk); #1;
            waits++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb_q.push_back(sub_word(d));
    endtask

    // Wait for the result, optionally stall, then take it.
    task automatic recv(input string tag, input int stall, output logic [127:0] obs);
        int lat;
        logic [127:0] hold;
        logic [127:0] exp;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
        check({tag, "_latency"}, 128'(lat), 128'(LAT));
        hold = bus.out_data;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_stall_data"}, bus.out_data, hold);
            check({tag, "_stall_valid"}, 128'(bus.out_valid), 128'd1);
            check({tag, "_stall_in_ready"}, 128'(bus.in_ready), 128'd0);
        end
        check({tag, "_sb_nonempty"}, 128'(sb_q.size() != 0), 128'd1);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
        obs = bus.out_data;
        check({tag, "_data"}, obs, exp);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_low"}, 128'(bus.out_valid), 128'd0);
        check({tag, "_in_ready_back"}, 128'(bus.in_ready), 128'd1);
        $display("txn %s out=%h exp=%h latency=%0d stall=%0d", tag, obs, exp, lat, stall);
    endtask

    initial begin
        logic [127:0] obs;
        int waits;
        bit seen;
        logic [127:0] w;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        build_model();

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_data", bus.out_data, 128'h0);
        check("rst_busy", 128'(busy), 128'd0);

        // All-zero word
        send(128'h0, waits);
        check("zero_busy", 128'(busy), 128'd1);
        check("zero_in_ready", 128'(bus.in_ready), 128'd0);
        recv("zero", 0, obs);
        check("zero_const", obs, 128'h63636363636363636363636363636363);

        // FIPS-197 round 1
        send(128'h193de3bea0f4e22b9ac68d2ae9f84808, waits);
        recv("fips", 0, obs);
        check("fips_const", obs, 128'hd42711aee0bf98f1b8b45de51e415230);

        // Backpressure, then immediate acceptance of the next word
        send(128'h00112233445566778899aabbccddeeff, waits);
        recv("bp", 10, obs);
        send(128'hffeeddccbbaa99887766554433221100, waits);
        check("bp_next_accept_waits", 128'(waits), 128'd0);
        recv("bp_next", 0, obs);

        // Abort in the second BUSY cycle with a word offered
        bus.in_valid = 1'b1;
        bus.in_data  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        @(posedge clk); #1;
        check("abort_busy", 128'(busy), 128'd1);
        bus.in_data  = 128'h0123456789abcdef0123456789abcdef;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 128'(bus.in_ready), 128'd1);
        check("abort_busy_low", 128'(busy), 128'd0);
        check("abort_out_valid", 128'(bus.out_valid), 128'd0);
        // clear still high with in_valid in IDLE: the word must be refused
        @(posedge clk); #1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        check("clear_prio_in_ready", 128'(bus.in_ready), 128'd1);
        check("clear_prio_busy", 128'(busy), 128'd0);
        seen = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", 128'(seen), 128'd0);
        send(128'h000153ff000000000000000000000000, waits);
        recv("after_abort", 0, obs);
        check("after_abort_const", obs, 128'h637ced16636363636363636363636363);

        // Exhaustive table with random stalls
        for (int v = 0; v < 256; v++) begin
            w = {16{8'(v)}};
            send(w, waits);
            recv($sformatf("tbl%0d", v), int'($urandom_range(0, 3)), obs);
            check("tbl_inverse", 128'(inv_m[obs[127:120]]), 128'(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
